// File: rtl/tff_count_sequencer.sv
// Sequencer for a W-bit bank of T flip-flops acting as a programmable modulo counter.
// It produces the per-bit toggle vector and holds the bank state, with start/stop/pause and one-shot or continuous modes.
module tff_count_sequencer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic         mode_cont,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] t_vec,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         wrap,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] mod_r;
  logic         cont_r;
  logic         terminal;
  logic         accept;
  logic [W-1:0] inc_t;

  assign accept = (state == IDLE) && start && !stop;

  // A stored modulus of 0 means the full 2**W range, so the terminal count is all-ones.
  always_comb begin
    if (mod_r == '0) terminal = (count == '1);
    else             terminal = (count == mod_r - W'(1));
  end

  // Bits that flip on a binary increment: bit i toggles when all lower bits are set.
  assign inc_t = count ^ (count + W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (stop)                            state_nxt = IDLE;
        else if (en && terminal && !cont_r)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    t_vec = '0;
    wrap  = 1'b0;
    busy  = (state == RUN);
    done  = (state == DONE);
    if (state == RUN && en) begin
      t_vec = terminal ? count : inc_t;
      wrap  = terminal;
    end
  end

  // The bank only evolves by the T-FF rule while running; every other path parks it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      mod_r  <= '0;
      cont_r <= 1'b0;
    end else begin
      if (accept) begin
        mod_r  <= modulus;
        cont_r <= mode_cont;
      end
      if (state == RUN && !stop) count <= count ^ t_vec;
      else                       count <= '0;
    end
  end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Scoreboard bench for tff_count_sequencer: directed scenarios plus random traffic against an arithmetic model.
module tb_tff_count_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         en = 1'b0;
  logic         mode_cont = 1'b0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] t_vec;
  logic [W-1:0] count;
  logic         busy;
  logic         wrap;
  logic         done;

  always #5 clk = ~clk;

  tff_count_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
    .mode_cont(mode_cont), .modulus(modulus), .t_vec(t_vec), .count(count),
    .busy(busy), .wrap(wrap), .done(done)
  );

  typedef struct packed {
    logic [W-1:0] t;
    logic [W-1:0] c;
    logic         b;
    logic         w;
    logic         d;
    logic         link;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: counting expressed as integer arithmetic modulo the effective modulus.
  bit m_run = 0;
  bit m_done = 0;
  bit m_cont = 0;
  int m_cnt = 0;
  int m_mt = 1 << W;
  bit link_next = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic e, input logic mc,
                      input logic [W-1:0] m);
    exp_t x;
    int   nxt;
    @(negedge clk);
    start = s; stop = p; en = e; mode_cont = mc; modulus = m;
    x.c = W'(m_cnt);
    x.b = m_run;
    x.d = m_done;
    x.t = '0;
    x.w = 1'b0;
    x.link = link_next;
    nxt = 0;
    if (m_run && e) begin
      nxt = (m_cnt + 1) % m_mt;
      x.t = W'(m_cnt ^ nxt);
      x.w = (m_cnt == m_mt - 1);
    end
    sb.push_back(x);
    link_next = !(m_run && p);
    if (m_done) begin
      m_done = 0;
      m_cnt = 0;
    end else if (m_run) begin
      if (p) begin
        m_run = 0;
        m_cnt = 0;
      end else if (e) begin
        if (x.w && !m_cont) begin
          m_run = 0;
          m_done = 1;
          m_cnt = 0;
        end else begin
          m_cnt = nxt;
        end
      end
    end else if (s && !p) begin
      m_run = 1;
      m_cnt = 0;
      m_mt = (m == '0) ? (1 << W) : int'(m);
      m_cont = mc;
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_t_vec", t_vec, '0);
    chk("rst_count", count, '0);
    chk("rst_busy", busy, '0);
    chk("rst_wrap", wrap, '0);
    chk("rst_done", done, '0);
    m_run = 0; m_done = 0; m_cnt = 0; m_cont = 0; m_mt = 1 << W; link_next = 0;
    start = 1'b0; stop = 1'b0; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid low-phase.
  initial begin
    exp_t         e;
    logic [W-1:0] prev_c;
    logic [W-1:0] prev_t;
    prev_c = '0;
    prev_t = '0;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("t_vec", t_vec, e.t);
        chk("count", count, e.c);
        chk("busy", busy, e.b);
        chk("wrap", wrap, e.w);
        chk("done", done, e.d);
        chk("wrap_done_excl", wrap & done, '0);
        if (e.link) chk("tff_rule", count, prev_c ^ prev_t);
        prev_c = count;
        prev_t = t_vec;
      end
    end
  end

  initial begin
    #2;
    chk("init_t_vec", t_vec, '0);
    chk("init_count", count, '0);
    chk("init_busy", busy, '0);
    chk("init_done", done, '0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot, M=5
    step(1, 0, 1, 0, 4'd5);
    repeat (8) step(0, 0, 1, 0, 4'd5);

    // Continuous, full range, then stop
    step(1, 0, 1, 1, 4'd0);
    repeat (40) step(0, 0, 1, 1, 4'd0);
    step(0, 1, 1, 1, 4'd0);
    step(0, 0, 1, 1, 4'd0);

    // Pause at 6, then stop
    step(1, 0, 1, 0, 4'd10);
    repeat (6) step(0, 0, 1, 0, 4'd10);
    repeat (3) step(0, 0, 0, 0, 4'd10);
    step(0, 1, 1, 0, 4'd10);
    repeat (2) step(0, 0, 1, 0, 4'd10);

    // start together with stop in IDLE
    repeat (2) step(1, 1, 1, 0, 4'd3);
    step(0, 0, 1, 0, 4'd3);

    // M=1 one-shot
    step(1, 0, 1, 0, 4'd1);
    repeat (3) step(0, 0, 1, 0, 4'd1);

    // start during DONE is ignored
    step(1, 0, 1, 0, 4'd2);
    repeat (2) step(0, 0, 1, 0, 4'd2);
    step(1, 0, 1, 0, 4'd7);
    repeat (3) step(0, 0, 1, 0, 4'd7);

    // Reset mid-sequence
    step(1, 0, 1, 1, 4'd9);
    repeat (5) step(0, 0, 1, 1, 4'd9);
    mid_reset();
    repeat (2) step(0, 0, 1, 0, 4'd9);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
      if (k % 131 == 130) mid_reset();
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #4;
    chk("scoreboard_drained", W'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
